cpu_sequencer: RTL and testbench

- Eight-phase instruction sequencer for the 8-bit accumulator CPU.
- Takes the 3-bit opcode from the instruction register and the accumulator-zero flag from the ALU.
- Drives memory, IR, PC, accumulator and bus-enable strobes, stepping one phase per enabled clock.
- Latches a sticky halt on HLT.

---
 rtl/cpu_sequencer.sv | 128 ++++++++++++
 tb/tb_cpu_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer for the 8-bit accumulator CPU.
// A 3-bit phase counter plus a sticky halt flag; every strobe is decoded combinationally.
module cpu_sequencer #(
    parameter logic [2:0] OPC_HLT = 3'h0,
    parameter logic [2:0] OPC_SKZ = 3'h1,
    parameter logic [2:0] OPC_ADD = 3'h2,
    parameter logic [2:0] OPC_AND = 3'h3,
    parameter logic [2:0] OPC_XOR = 3'h4,
    parameter logic [2:0] OPC_LDA = 3'h5,
    parameter logic [2:0] OPC_STO = 3'h6,
    parameter logic [2:0] OPC_JMP = 3'h7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       data_e,
    output logic       wr,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic data_e;
        logic wr;
        logic halt;
    } ctl_t;

    phase_t phase_q, phase_d;
    logic   halted_q, halted_d;
    ctl_t   ctl;
    logic   aluop, is_hlt;

    assign aluop  = (opcode == OPC_ADD) || (opcode == OPC_AND) ||
                    (opcode == OPC_XOR) || (opcode == OPC_LDA);
    assign is_hlt = (opcode == OPC_HLT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        ctl      = '0;
        // HLT in OP_ADDR freezes the counter there instead of advancing
        if (!halted_q && en) begin
            if (phase_q == OP_ADDR && is_hlt) halted_d = 1'b1;
            else                               phase_d  = phase_t'(phase_q + 3'd1);
        end

        if (halted_q) begin
            ctl.halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR:  ctl.sel = 1'b1;
                INST_FETCH: begin ctl.sel = 1'b1; ctl.rd = 1'b1; end
                INST_LOAD, IDLE: begin
                    ctl.sel   = 1'b1;
                    ctl.rd    = 1'b1;
                    ctl.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    ctl.inc_pc = !is_hlt;
                    ctl.halt   = is_hlt;
                end
                OP_FETCH: ctl.rd = aluop;
                ALU_OP: begin
                    ctl.rd     = aluop;
                    ctl.inc_pc = (opcode == OPC_SKZ) && zero;
                    ctl.ld_pc  = (opcode == OPC_JMP);
                    ctl.data_e = (opcode == OPC_STO);
                end
                STORE: begin
                    ctl.rd     = aluop;
                    ctl.ld_ac  = aluop;
                    ctl.inc_pc = (opcode == OPC_JMP);
                    ctl.ld_pc  = (opcode == OPC_JMP);
                    ctl.data_e = (opcode == OPC_STO);
                    ctl.wr     = (opcode == OPC_STO);
                end
                default: ctl = '0;
            endcase
        end
    end

    assign sel    = ctl.sel;
    assign rd     = ctl.rd;
    assign ld_ir  = ctl.ld_ir;
    assign inc_pc = ctl.inc_pc;
    assign ld_pc  = ctl.ld_pc;
    assign ld_ac  = ctl.ld_ac;
    assign data_e = ctl.data_e;
    assign wr     = ctl.wr;
    assign halt   = ctl.halt;
    assign phase  = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-phase strobe tables for each opcode class.
module tb_cpu_sequencer;

    logic       clk, rst_n, en, zero;
    logic [2:0] opcode;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
    logic [2:0] phase;
    logic [8:0] st;

    int n_chk  = 0;
    int n_pass = 0;

    // strobe vector order: sel rd ld_ir inc_pc ld_pc ld_ac data_e wr halt
    assign st = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};

    cpu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
        .ld_ac(ld_ac), .data_e(data_e), .wr(wr), .halt(halt), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [8:0] S_P0  = 9'b100000000;
    localparam logic [8:0] S_P1  = 9'b110000000;
    localparam logic [8:0] S_P23 = 9'b111000000;
    localparam logic [8:0] S_INC = 9'b000100000;
    localparam logic [8:0] S_NIL = 9'b000000000;
    localparam logic [8:0] S_HLT = 9'b000000001;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs phases 0..7 of one instruction, checking each phase, and leaves
    // the sequencer at phase 0 of the next instruction. zv gives zero per phase.
    task automatic run_instr(input string name, input logic [2:0] op,
                             input logic [7:0] zv, input logic [7:0][8:0] ex);
        opcode = op;
        for (int p = 0; p < 8; p++) begin
            zero = zv[p];
            #1;
            chk($sformatf("%s_ph%0d", name, p), 32'(phase), 32'(p));
            chk($sformatf("%s_st%0d", name, p), 32'(st), 32'(ex[p]));
            tick();
        end
        chk({name, "_wrap"}, 32'(phase), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; zero = 1'b0; opcode = 3'h2;
        #2;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_st", 32'(st), 32'(S_P0));
        #10 rst_n = 1'b1;
        en = 1'b1;

        // 1: ADD
        run_instr("add", 3'h2, 8'h00,
            {9'b010001000, 9'b010000000, 9'b010000000, S_INC, S_P23, S_P23, S_P1, S_P0});
        // 2: STO
        run_instr("sto", 3'h6, 8'h00,
            {9'b000000110, 9'b000000100, S_NIL, S_INC, S_P23, S_P23, S_P1, S_P0});
        // 3: SKZ taken, not taken, and zero pulsed only in phase 5
        run_instr("skz1", 3'h1, 8'h40,
            {S_NIL, S_INC, S_NIL, S_INC, S_P23, S_P23, S_P1, S_P0});
        run_instr("skz0", 3'h1, 8'h00,
            {S_NIL, S_NIL, S_NIL, S_INC, S_P23, S_P23, S_P1, S_P0});
        run_instr("skz5", 3'h1, 8'h20,
            {S_NIL, S_NIL, S_NIL, S_INC, S_P23, S_P23, S_P1, S_P0});
        // 4: JMP
        run_instr("jmp", 3'h7, 8'hFF,
            {9'b000110000, 9'b000010000, S_NIL, S_INC, S_P23, S_P23, S_P1, S_P0});

        // 5: HLT
        opcode = 3'h0; zero = 1'b0;
        repeat (4) tick();
        chk("hlt_ph4", 32'(phase), 32'd4);
        chk("hlt_st4", 32'(st), 32'(S_HLT));
        repeat (10) tick();
        chk("hlt_frozen_ph", 32'(phase), 32'd4);
        chk("hlt_frozen_st", 32'(st), 32'(S_HLT));
        opcode = 3'h2; zero = 1'b1;
        tick();
        chk("hlt_add_ph", 32'(phase), 32'd4);
        chk("hlt_add_st", 32'(st), 32'(S_HLT));
        en = 1'b0; opcode = 3'h1;
        tick();
        chk("hlt_en0_st", 32'(st), 32'(S_HLT));
        #2 rst_n = 1'b0;
        #1;
        chk("hlt_rst_ph", 32'(phase), 32'd0);
        chk("hlt_rst_st", 32'(st), 32'(S_P0));
        #3 rst_n = 1'b1;
        tick();
        chk("hlt_rst_hold", 32'(phase), 32'd0);

        // 6: en=0 hold in phase 5, then async reset in phase 6 of a JMP
        en = 1'b1; opcode = 3'h7; zero = 1'b0;
        repeat (5) tick();
        chk("hold_ph5", 32'(phase), 32'd5);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_ph_%0d", i), 32'(phase), 32'd5);
            chk($sformatf("hold_st_%0d", i), 32'(st), 32'(S_NIL));
        end
        en = 1'b1;
        tick();
        chk("jmp_ph6", 32'(phase), 32'd6);
        chk("jmp_ldpc6", 32'(ld_pc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ldpc", 32'(ld_pc), 32'd0);
        chk("mid_rst_ph", 32'(phase), 32'd0);
        chk("mid_rst_st", 32'(st), 32'(S_P0));
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_ph", 32'(phase), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
